// File: rtl/wb_stage_pkg.sv
// Shared widths, load funct3 codes, state codes and the latched-load context.
package wb_stage_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned F3_W       = 3;

  localparam logic [F3_W-1:0] LD_LB  = 3'b000;
  localparam logic [F3_W-1:0] LD_LH  = 3'b001;
  localparam logic [F3_W-1:0] LD_LW  = 3'b010;
  localparam logic [F3_W-1:0] LD_LBU = 3'b100;
  localparam logic [F3_W-1:0] LD_LHU = 3'b101;

  localparam logic [0:0] WB_IDLE = 1'b0;
  localparam logic [0:0] WB_WAIT = 1'b1;

  // Everything a pending load needs once the memory response arrives.
  typedef struct packed {
    logic                  wen;
    logic [REG_ADDR_W-1:0] rd;
    logic [F3_W-1:0]       funct3;
    logic [1:0]            off;
  } ld_ctx_t;

endpackage

// File: rtl/wb_load_ext.sv
// Load data extraction: selects byte/half/word from an aligned read word and extends it.
module wb_load_ext
  import wb_stage_pkg::*;
(
  input  logic [F3_W-1:0]   funct3_i,
  input  logic [1:0]        off_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] data_c_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection; halves ignore off[0], words ignore the offset entirely.
  always_comb begin
    byte_sel = rdata_i[8*off_i +: 8];
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Width/sign handling; reserved codes fall back to a full word.
  always_comb begin
    data_c_o = rdata_i;
    case (funct3_i)
      LD_LB:   data_c_o = {{24{byte_sel[7]}}, byte_sel};
      LD_LH:   data_c_o = {{16{half_sel[15]}}, half_sel};
      LD_LBU:  data_c_o = {24'h0, byte_sel};
      LD_LHU:  data_c_o = {16'h0, half_sel};
      default: data_c_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: one-cycle ALU write-back, load completion with timeout, load-use hint.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  rd_wen_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0]     result_i,
  input  logic                  is_load_i,
  input  logic [F3_W-1:0]       funct3_i,
  input  logic                  flush_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  output logic                  wr_en_o,
  output logic [REG_ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0]     wr_data_o,
  output logic                  pend_valid_o,
  output logic [REG_ADDR_W-1:0] pend_addr_o,
  output logic                  err_o
);

  logic [0:0]            state_q,   state_d;
  ld_ctx_t               ctx_q,     ctx_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic                  wr_en_q,   wr_en_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;
  logic                  err_q,     err_d;
  logic [DATA_W-1:0]     ld_data;
  logic                  accept;
  logic                  timeout;

  wb_load_ext u_load_ext (
    .funct3_i (ctx_q.funct3),
    .off_i    (ctx_q.off),
    .rdata_i  (mem_rdata_i),
    .data_c_o (ld_data)
  );

  assign ready_o = (state_q == WB_IDLE) & ~flush_i;
  assign accept  = valid_i & ready_o;
  assign timeout = (MEM_TIMEOUT != 0) && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  // Next-state and write-back decisions.
  always_comb begin
    state_d   = state_q;
    ctx_d     = ctx_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = 1'b0;
    case (state_q)
      WB_IDLE: begin
        if (accept) begin
          if (is_load_i) begin
            ctx_d.wen    = rd_wen_i;
            ctx_d.rd     = rd_addr_i;
            ctx_d.funct3 = funct3_i;
            ctx_d.off    = result_i[1:0];
            cnt_d        = '0;
            state_d      = WB_WAIT;
          end else begin
            wr_en_d   = rd_wen_i & (rd_addr_i != '0);
            wr_addr_d = rd_addr_i;
            wr_data_d = result_i;
          end
        end
      end
      WB_WAIT: begin
        if (flush_i) begin
          state_d = WB_IDLE;
        end else if (mem_rvalid_i) begin
          wr_en_d   = ctx_q.wen & (ctx_q.rd != '0);
          wr_addr_d = ctx_q.rd;
          wr_data_d = ld_data;
          state_d   = WB_IDLE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = WB_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= WB_IDLE;
      ctx_q     <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctx_q     <= ctx_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign err_o        = err_q;
  assign pend_valid_o = (state_q == WB_WAIT) & ctx_q.wen & (ctx_q.rd != '0);
  assign pend_addr_o  = pend_valid_o ? ctx_q.rd : '0;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus random traffic against a transaction-level model.
module tb_wb_stage;

  localparam int unsigned TO = 16;

  logic        clk;
  logic        rst;
  logic        valid_i, rd_wen_i, is_load_i, flush_i, mem_rvalid_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] result_i, mem_rdata_i;
  logic [2:0]  funct3_i;
  logic        ready_o, wr_en_o, pend_valid_o, err_o;
  logic [4:0]  wr_addr_o, pend_addr_o;
  logic [31:0] wr_data_o;

  int total = 0;
  int bad   = 0;

  // Model: whether a load is outstanding, what it carries, how long it has waited.
  bit          m_wait;
  int          m_waited;
  logic        m_wen;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [1:0]  m_off;
  logic        e_wen, e_err;
  logic [4:0]  e_addr;
  logic [31:0] e_data;

  wb_stage #(.MEM_TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .rd_wen_i(rd_wen_i), .rd_addr_i(rd_addr_i), .result_i(result_i),
    .is_load_i(is_load_i), .funct3_i(funct3_i), .flush_i(flush_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .pend_valid_o(pend_valid_o), .pend_addr_o(pend_addr_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_extract(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] w);
    logic [31:0] v;
    case (f3)
      3'b000: begin v = (w >> (int'(off) * 8)) & 32'hFF;    if (v[7])  v = v | 32'hFFFF_FF00; end
      3'b001: begin v = (w >> (int'(off[1]) * 16)) & 32'hFFFF; if (v[15]) v = v | 32'hFFFF_0000; end
      3'b100: v = (w >> (int'(off) * 8)) & 32'hFF;
      3'b101: v = (w >> (int'(off[1]) * 16)) & 32'hFFFF;
      default: v = w;
    endcase
    return v;
  endfunction

  // Advance the model by one clock given the inputs that were presented.
  task automatic model_step();
    e_wen = 1'b0;
    e_err = 1'b0;
    if (!m_wait) begin
      if (valid_i && !flush_i) begin
        if (is_load_i) begin
          m_wait = 1; m_waited = 0;
          m_wen = rd_wen_i; m_rd = rd_addr_i; m_f3 = funct3_i; m_off = result_i[1:0];
        end else begin
          e_wen  = rd_wen_i && (rd_addr_i != 5'd0);
          e_addr = rd_addr_i;
          e_data = result_i;
        end
      end
    end else if (flush_i) begin
      m_wait = 0;
    end else if (mem_rvalid_i) begin
      e_wen  = m_wen && (m_rd != 5'd0);
      e_addr = m_rd;
      e_data = ref_extract(m_f3, m_off, mem_rdata_i);
      m_wait = 0;
    end else begin
      m_waited++;
      if (m_waited == TO) begin
        e_err  = 1'b1;
        m_wait = 0;
      end
    end
  endtask

  // One clock of stimulus with checks before and after the edge.
  task automatic cycle(input logic v, input logic wen, input logic [4:0] rd, input logic [31:0] res,
                       input logic ld, input logic [2:0] f3, input logic fl, input logic rv,
                       input logic [31:0] rdata);
    logic exp_pend;
    @(negedge clk);
    valid_i = v; rd_wen_i = wen; rd_addr_i = rd; result_i = res; is_load_i = ld;
    funct3_i = f3; flush_i = fl; mem_rvalid_i = rv; mem_rdata_i = rdata;
    #1;
    exp_pend = m_wait && m_wen && (m_rd != 5'd0);
    check("ready", 32'(ready_o), 32'(!m_wait && !fl));
    check("pend_valid", 32'(pend_valid_o), 32'(exp_pend));
    if (exp_pend) check("pend_addr", 32'(pend_addr_o), 32'(m_rd));
    @(posedge clk);
    model_step();
    #1;
    check("wr_en", 32'(wr_en_o), 32'(e_wen));
    check("err", 32'(err_o), 32'(e_err));
    if (e_wen) begin
      check("wr_addr", 32'(wr_addr_o), 32'(e_addr));
      check("wr_data", wr_data_o, e_data);
    end
  endtask

  task automatic idle_inputs();
    valid_i = 0; rd_wen_i = 0; rd_addr_i = 0; result_i = 0; is_load_i = 0;
    funct3_i = 0; flush_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, 32'(wr_en_o), 32'd0);
    check({tag, "_err"}, 32'(err_o), 32'd0);
    check({tag, "_pend"}, 32'(pend_valid_o), 32'd0);
    check({tag, "_pend_addr"}, 32'(pend_addr_o), 32'd0);
    check({tag, "_wr_addr"}, 32'(wr_addr_o), 32'd0);
    check({tag, "_wr_data"}, wr_data_o, 32'd0);
    check({tag, "_ready"}, 32'(ready_o), 32'd1);
  endtask

  initial begin
    int rvp;
    m_wait = 0; m_waited = 0; m_wen = 0; m_rd = 0; m_f3 = 0; m_off = 0;
    e_wen = 0; e_err = 0; e_addr = 0; e_data = 0;
    idle_inputs();
    rst = 1'b1;
    #3;
    check_reset_outputs("por");
    @(negedge clk); #2 rst = 1'b0;

    // ALU write to x5
    cycle(1, 1, 5'd5, 32'h1234_5678, 0, 3'b000, 0, 0, 32'h0);
    check("alu_data", wr_data_o, 32'h1234_5678);
    check("alu_addr", 32'(wr_addr_o), 32'd5);

    // Back-to-back ALU writes to x1..x3
    for (int i = 1; i <= 3; i++) cycle(1, 1, 5'(i), 32'(i * 32'h111), 0, 3'b000, 0, 0, 32'h0);

    // ALU with rd_wen=0 and ALU to x0: no write
    cycle(1, 0, 5'd7, 32'hDEAD_BEEF, 0, 3'b000, 0, 0, 32'h0);
    cycle(1, 1, 5'd0, 32'hDEAD_BEEF, 0, 3'b000, 0, 0, 32'h0);

    // LB off=3, response two cycles after accept
    cycle(1, 1, 5'd5, 32'h0000_1003, 1, 3'b000, 0, 0, 32'h0);
    cycle(1, 1, 5'd9, 32'h0, 0, 3'b000, 0, 0, 32'h0);
    check("lb_pend_addr", 32'(pend_addr_o), 32'd5);
    cycle(0, 0, 5'd0, 32'h0, 0, 3'b000, 0, 1, 32'h80AA_BBCC);
    check("lb_data", wr_data_o, 32'hFFFF_FF80);

    // LHU off=2
    cycle(1, 1, 5'd6, 32'h0000_0002, 1, 3'b101, 0, 0, 32'h0);
    cycle(0, 0, 5'd0, 32'h0, 0, 3'b000, 0, 1, 32'h8001_0000);
    check("lhu_data", wr_data_o, 32'h0000_8001);

    // LW to x0: waits, never writes, never flags pending
    cycle(1, 1, 5'd0, 32'h0, 1, 3'b010, 0, 0, 32'h0);
    cycle(0, 0, 5'd0, 32'h0, 0, 3'b000, 0, 0, 32'h0);
    check("lw_x0_pend", 32'(pend_valid_o), 32'd0);
    cycle(0, 0, 5'd0, 32'h0, 0, 3'b000, 0, 1, 32'h1111_2222);

    // Timeout: 16 cycles without a response
    cycle(1, 1, 5'd8, 32'h0, 1, 3'b010, 0, 0, 32'h0);
    for (int i = 0; i < 16; i++) cycle(0, 0, 5'd0, 32'h0, 0, 3'b000, 0, 0, 32'h0);
    check("timeout_err", 32'(err_o), 32'd1);
    cycle(0, 0, 5'd0, 32'h0, 0, 3'b000, 0, 0, 32'h0);

    // Response on the last allowed cycle wins over the timeout
    cycle(1, 1, 5'd10, 32'h1, 1, 3'b100, 0, 0, 32'h0);
    for (int i = 0; i < 15; i++) cycle(0, 0, 5'd0, 32'h0, 0, 3'b000, 0, 0, 32'h0);
    cycle(0, 0, 5'd0, 32'h0, 0, 3'b000, 0, 1, 32'h0000_F500);
    check("late_rvalid_data", wr_data_o, 32'h0000_00F5);

    // Flush and response together: no write
    cycle(1, 1, 5'd11, 32'h0, 1, 3'b010, 0, 0, 32'h0);
    cycle(0, 0, 5'd0, 32'h0, 0, 3'b000, 1, 1, 32'hCAFE_F00D);
    check("flush_wr_en", 32'(wr_en_o), 32'd0);

    // Stale response in IDLE, and flush blocking an incoming ALU op
    cycle(0, 0, 5'd0, 32'h0, 0, 3'b000, 0, 1, 32'h5555_5555);
    cycle(1, 1, 5'd12, 32'h77, 0, 3'b000, 1, 0, 32'h0);

    // Async reset while a load is outstanding
    cycle(1, 1, 5'd13, 32'h0, 1, 3'b000, 0, 0, 32'h0);
    cycle(0, 0, 5'd0, 32'h0, 0, 3'b000, 0, 0, 32'h0);
    @(negedge clk);
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    m_wait = 0; m_waited = 0;
    #1 rst = 1'b0;

    // Random traffic; the second half rarely answers loads so timeouts occur
    for (int i = 0; i < 600; i++) begin
      rvp = (i < 300) ? 30 : 3;
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0,
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), 32'($urandom),
            $urandom_range(0, 9) < 4, 3'($urandom), $urandom_range(0, 19) == 0,
            $urandom_range(0, 99) < rvp, 32'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
